// File: rtl/logic_pkg.sv
// Shared definitions for the logic_* block library.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// target_t selects an implementation flavour for blocks that offer more than
// one. It never changes cycle behaviour, only how logic may be mapped.
package logic_pkg;

  typedef enum logic [1:0] {
    TARGET_GENERIC = 2'd0,
    TARGET_ASIC    = 2'd1,
    TARGET_FPGA    = 2'd2
  } target_t;

endpackage : logic_pkg

// File: rtl/logic_arbiter_round_robin_select.sv
// Round-robin requester search: first set request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   req        in   INPUTS  request vector
//   ptr        in   IDX_W   search start index (must be < INPUTS)
//   grant_oh   out  INPUTS  one-hot winner, all zero when no request
//   grant_idx  out  IDX_W   binary winner index, zero when no request
module logic_arbiter_round_robin_select #(
  parameter int INPUTS = 2
) (
  input  logic [INPUTS-1:0]                          req,
  input  logic [(INPUTS > 1 ? $clog2(INPUTS) : 1)-1:0] ptr,
  output logic [INPUTS-1:0]                          grant_oh,
  output logic [(INPUTS > 1 ? $clog2(INPUTS) : 1)-1:0] grant_idx
);

  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  // ptr + off stays below 2*INPUTS, so a single conditional subtract wraps it.
  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= INPUTS) begin
      sum = sum - INPUTS;
    end
    return sum;
  endfunction

  always_comb begin
    logic found;
    int   cand;
    found     = 1'b0;
    cand      = 0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int k = 0; k < INPUTS; k++) begin
      cand = wrap_idx(int'(ptr), k);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IDX_W'(cand);
      end
    end
  end

endmodule : logic_arbiter_round_robin_select

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-level round-robin arbiter of INPUTS AXI4-Stream sources onto one output.
// Latency: 2 cycles request-to-first-beat, 1 cycle per beat inside a packet,
//          one idle bubble between packets.
// Backpressure: tx_tready feeds rx_tready[grant] combinationally; the output
//          register holds its beat stable while tx_tready is low.
//
// Ports:
//   aclk, areset_n  clock and asynchronous active-low reset
//   rx_tvalid/rx_tready/rx_tlast/rx_tdata  per-source AXI4-Stream inputs
//   tx_tvalid/tx_tready/tx_tlast/tx_tdata  shared registered output
//   tx_tid          index of the source that produced the current tx beat
module logic_axi4_stream_arbiter
  import logic_pkg::*;
#(
  parameter int                  INPUTS      = 2,
  parameter int                  TDATA_BYTES = 4,
  parameter logic_pkg::target_t  TARGET      = logic_pkg::TARGET_GENERIC
) (
  input  logic                                        aclk,
  input  logic                                        areset_n,
  input  logic [INPUTS-1:0]                           rx_tvalid,
  output logic [INPUTS-1:0]                           rx_tready,
  input  logic [INPUTS-1:0]                           rx_tlast,
  input  logic [INPUTS-1:0][8*TDATA_BYTES-1:0]        rx_tdata,
  output logic                                        tx_tvalid,
  input  logic                                        tx_tready,
  output logic                                        tx_tlast,
  output logic [8*TDATA_BYTES-1:0]                    tx_tdata,
  output logic [(INPUTS > 1 ? $clog2(INPUTS) : 1)-1:0] tx_tid
);

  localparam int              IDX_W    = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS - 1);

  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant;

  logic [INPUTS-1:0] sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;
  logic              out_free;
  logic              accept;

  // Every target maps onto the same portable logic; the hook exists so a
  // target-specific variant can be dropped in without touching the ports.
  if (TARGET == TARGET_GENERIC) begin : g_target_generic
  end else begin : g_target_other
  end

  logic_arbiter_round_robin_select #(
    .INPUTS (INPUTS)
  ) u_select (
    .req       (rx_tvalid),
    .ptr       (ptr),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx)
  );

  assign sel_any = |sel_oh;

  // The output register can take a beat if it is empty or draining this cycle.
  assign out_free = !tx_tvalid || tx_tready;
  assign accept   = (state == STATE_LOCKED) && rx_tvalid[grant] && out_free;

  // Only the locked source ever sees ready; this is the sole tx_tready path.
  always_comb begin
    rx_tready = '0;
    if (state == STATE_LOCKED) begin
      rx_tready[grant] = out_free;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= STATE_IDLE;
      ptr       <= '0;
      grant     <= '0;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tdata  <= '0;
      tx_tid    <= '0;
    end else begin
      if (accept) begin
        tx_tvalid <= 1'b1;
        tx_tdata  <= rx_tdata[grant];
        tx_tlast  <= rx_tlast[grant];
        tx_tid    <= grant;
      end else if (tx_tready) begin
        tx_tvalid <= 1'b0;
      end

      case (state)
        STATE_IDLE: begin
          if (sel_any) begin
            grant <= sel_idx;
            state <= STATE_LOCKED;
          end
        end
        STATE_LOCKED: begin
          // Lock is released only by an accepted tlast; gaps keep ownership.
          if (accept && rx_tlast[grant]) begin
            ptr   <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule : logic_axi4_stream_arbiter

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Randomized bench for logic_axi4_stream_arbiter with INPUTS=3 (non power of two).
// Reference: packet-ownership model plus an expected-beat queue for the output.
// Sources obey AXI rules: data held stable until accepted, gaps allowed.
module tb_logic_axi4_stream_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic                 aclk = 1'b0;
  logic                 areset_n = 1'b0;
  logic [N-1:0]         rx_tvalid;
  logic [N-1:0]         rx_tready;
  logic [N-1:0]         rx_tlast;
  logic [N-1:0][DW-1:0] rx_tdata;
  logic                 tx_tvalid;
  logic                 tx_tready;
  logic                 tx_tlast;
  logic [DW-1:0]        tx_tdata;
  logic [IW-1:0]        tx_tid;

  always #5 aclk = ~aclk;

  logic_axi4_stream_arbiter #(
    .INPUTS      (N),
    .TDATA_BYTES (DW / 8),
    .TARGET      (logic_pkg::TARGET_GENERIC)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .rx_tlast  (rx_tlast),
    .rx_tdata  (rx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tlast  (tx_tlast),
    .tx_tdata  (tx_tdata),
    .tx_tid    (tx_tid)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs.
  int p_valid = 100;
  int p_ready = 100;
  int max_len = 1;

  // Source state: beats left in current packet, accepted-last-cycle flags.
  int rem [N];
  bit acc [N];

  // Reference model.
  bit    m_locked;
  int    m_owner;
  int    m_ptr;
  beat_t exp_q[$];

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    exp_q.delete();
    for (int s = 0; s < N; s++) begin
      rem[s] = 0;
      acc[s] = 1'b0;
    end
    rx_tvalid = '0;
    rx_tlast  = '0;
  endtask

  task automatic drive_sources();
    for (int s = 0; s < N; s++) begin
      if (acc[s]) begin
        rem[s]--;
        rx_tvalid[s] = 1'b0;
      end
      if (!rx_tvalid[s] && ($urandom_range(99) < p_valid)) begin
        if (rem[s] == 0) rem[s] = $urandom_range(max_len, 1);
        rx_tvalid[s] = 1'b1;
        rx_tdata[s]  = $urandom;
        rx_tlast[s]  = (rem[s] == 1);
      end
    end
    tx_tready = ($urandom_range(99) < p_ready);
  endtask

  // One clock: check at negedge, advance model, drive after posedge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    bit           hs;
    bit           found;
    beat_t        b;
    @(negedge aclk);
    exp_rdy = '0;
    if (m_locked && (exp_q.size() == 0 || tx_tready)) exp_rdy[m_owner] = 1'b1;
    chk("rx_tready", 64'(rx_tready), 64'(exp_rdy));
    chk("tx_tvalid", 64'(tx_tvalid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("tx_tid", 64'(tx_tid), 64'(exp_q[0].tid));
      chk("tx_tdata", 64'(tx_tdata), 64'(exp_q[0].data));
      chk("tx_tlast", 64'(tx_tlast), 64'(exp_q[0].last));
    end

    for (int s = 0; s < N; s++) acc[s] = rx_tvalid[s] && exp_rdy[s];
    hs = m_locked && acc[m_owner];

    if (exp_q.size() != 0 && tx_tready) void'(exp_q.pop_front());
    if (hs) begin
      b.tid  = IW'(m_owner);
      b.data = rx_tdata[m_owner];
      b.last = rx_tlast[m_owner];
      exp_q.push_back(b);
    end

    if (!m_locked) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && rx_tvalid[(m_ptr + k) % N]) begin
          found    = 1'b1;
          m_owner  = (m_ptr + k) % N;
          m_locked = 1'b1;
        end
      end
    end else if (hs && rx_tlast[m_owner]) begin
      m_ptr    = (m_owner + 1) % N;
      m_locked = 1'b0;
    end

    @(posedge aclk);
    #1;
    drive_sources();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_tvalid"}, 64'(tx_tvalid), 64'd0);
    chk({tag, "_tx_tlast"},  64'(tx_tlast),  64'd0);
    chk({tag, "_tx_tdata"},  64'(tx_tdata),  64'd0);
    chk({tag, "_tx_tid"},    64'(tx_tid),    64'd0);
    chk({tag, "_rx_tready"}, 64'(rx_tready), 64'd0);
  endtask

  task automatic run(input int cycles, input int pv, input int pr, input int ml);
    p_valid = pv;
    p_ready = pr;
    max_len = ml;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rx_tdata  = '0;
    tx_tready = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9;
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    drive_sources();

    // All sources streaming single-beat packets: strict rotation, one beat per 2 cycles.
    run(40, 100, 100, 1);
    // Mixed packet lengths with gaps and moderate backpressure.
    run(1500, 60, 70, 6);
    // Heavy backpressure on long packets.
    run(500, 80, 30, 6);

    // Reset in the middle of a multi-beat packet.
    begin
      int  waited;
      bit  hit;
      hit = 1'b0;
      p_valid = 100; p_ready = 100; max_len = 6;
      for (waited = 0; waited < 2000 && !hit; waited++) begin
        step();
        if (m_locked && exp_q.size() != 0 && !exp_q[0].last && rem[m_owner] >= 2) hit = 1'b1;
      end
      chk("reset_wait_timeout", 64'(hit), 64'd1);
      #2;
      areset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge aclk);
      check_all_zero("inreset");
      @(posedge aclk);
      #3;
      areset_n = 1'b1;
      drive_sources();
    end

    // After reset all sources request at once: rotation must restart at source 0.
    run(20, 100, 100, 1);
    run(800, 50, 60, 5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_logic_axi4_stream_arbiter
